// File: rtl/compress_channel_sequencer_if.sv
// rtl/compress_channel_sequencer_if.sv - pooled-beat, compressor, writeback and descriptor signals of the channel sequencer
interface compress_channel_sequencer_if #(
    parameter int POOL_W = 4,
    parameter int CH_W   = 6,
    parameter int CNT_W  = 8,
    parameter int ADDR_W = 12
);
    logic              cfg_start;
    logic [CH_W-1:0]   cfg_num_ch;
    logic [ADDR_W-1:0] cfg_base_addr;
    logic [POOL_W-1:0] in_lane_valid;
    logic              in_ready;
    logic              compress_restart;
    logic [POOL_W-1:0] cu_lane_valid;
    logic [CNT_W-1:0]  cu_count;
    logic              cu_count_valid;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              desc_valid;
    logic              desc_ready;
    logic [CH_W-1:0]   desc_ch;
    logic [ADDR_W-1:0] desc_base;
    logic [CNT_W-1:0]  desc_count;
    logic              busy;
    logic              done;
    logic              err_align;
    logic              err_count;

    modport slave (
        input  cfg_start, cfg_num_ch, cfg_base_addr, in_lane_valid,
               cu_lane_valid, cu_count, cu_count_valid, desc_ready,
        output in_ready, compress_restart, wr_en, wr_addr, desc_valid,
               desc_ch, desc_base, desc_count, busy, done, err_align, err_count
    );

    modport master (
        output cfg_start, cfg_num_ch, cfg_base_addr, in_lane_valid,
               cu_lane_valid, cu_count, cu_count_valid, desc_ready,
        input  in_ready, compress_restart, wr_en, wr_addr, desc_valid,
               desc_ch, desc_base, desc_count, busy, done, err_align, err_count
    );
endinterface

// File: rtl/compress_channel_sequencer.sv
// rtl/compress_channel_sequencer.sv - per-channel compressor restart, packed write addressing and descriptor FIFO
module compress_channel_sequencer #(
    parameter int POOL_W     = 4,
    parameter int CH_ELEMS   = 64,
    parameter int CH_W       = 6,
    parameter int CNT_W      = 8,
    parameter int ADDR_W     = 12,
    parameter int DESC_DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    compress_channel_sequencer_if.slave bus
);
    localparam int PW = $clog2(POOL_W + 1);
    localparam int EW = $clog2(CH_ELEMS + POOL_W);
    localparam int AW = $clog2(DESC_DEPTH);
    localparam int FW = AW + 2;
    localparam logic [EW-1:0] L_CH    = EW'(CH_ELEMS);
    localparam logic [FW-1:0] L_DEPTH = FW'(DESC_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            r_state;
    logic [CH_W-1:0]   r_num_ch;
    logic [CH_W-1:0]   r_ch;
    logic [EW-1:0]     r_elem_cnt;
    logic              r_pending;
    logic [CH_W-1:0]   r_pend_ch;
    logic [ADDR_W-1:0] r_pend_base;
    logic [ADDR_W-1:0] r_cur_base;
    logic [ADDR_W-1:0] r_ptr;
    logic [CNT_W-1:0]  r_loc_cnt;
    logic              r_busy;
    logic              r_done;
    logic              r_err_align;
    logic              r_err_count;

    logic [CH_W-1:0]   r_mem_ch    [DESC_DEPTH];
    logic [ADDR_W-1:0] r_mem_base  [DESC_DEPTH];
    logic [CNT_W-1:0]  r_mem_count [DESC_DEPTH];
    logic [AW-1:0]     r_wr_idx;
    logic [AW-1:0]     r_rd_idx;
    logic [FW-1:0]     r_fifo_cnt;

    logic [PW-1:0]     w_in_pop;
    logic [PW-1:0]     w_cu_pop;
    logic [EW-1:0]     w_sum;
    logic              w_active;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_restart;
    logic              w_push;
    logic              w_desc_valid;
    logic              w_pop;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_ptr_next;

    always_comb begin
        w_in_pop = '0;
        w_cu_pop = '0;
        for (int i = 0; i < POOL_W; i++) begin
            w_in_pop = w_in_pop + PW'(bus.in_lane_valid[i]);
            w_cu_pop = w_cu_pop + PW'(bus.cu_lane_valid[i]);
        end
    end

    // A pending descriptor reserves its FIFO slot so the push one cycle later always fits.
    assign w_active     = (r_state != S_IDLE);
    assign w_in_ready   = (r_state == S_RUN) && ((r_fifo_cnt + FW'(r_pending)) < L_DEPTH);
    assign w_accept     = w_in_ready && (|bus.in_lane_valid);
    assign w_sum        = r_elem_cnt + EW'(w_in_pop);
    assign w_restart    = w_accept && (w_sum >= L_CH);
    assign w_push       = bus.cu_count_valid && r_pending;
    assign w_desc_valid = (r_fifo_cnt != '0);
    assign w_pop        = w_desc_valid && bus.desc_ready;
    assign w_wr_en      = w_active && (|bus.cu_lane_valid);
    assign w_ptr_next   = w_wr_en ? (r_ptr + ADDR_W'(w_cu_pop)) : r_ptr;

    assign bus.in_ready         = w_in_ready;
    assign bus.compress_restart = w_restart;
    assign bus.wr_en            = w_wr_en;
    assign bus.wr_addr          = r_ptr;
    assign bus.desc_valid       = w_desc_valid;
    assign bus.desc_ch          = w_desc_valid ? r_mem_ch[r_rd_idx]    : '0;
    assign bus.desc_base        = w_desc_valid ? r_mem_base[r_rd_idx]  : '0;
    assign bus.desc_count       = w_desc_valid ? r_mem_count[r_rd_idx] : '0;
    assign bus.busy             = r_busy;
    assign bus.done             = r_done;
    assign bus.err_align        = r_err_align;
    assign bus.err_count        = r_err_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_num_ch    <= '0;
            r_ch        <= '0;
            r_elem_cnt  <= '0;
            r_pending   <= 1'b0;
            r_pend_ch   <= '0;
            r_pend_base <= '0;
            r_cur_base  <= '0;
            r_ptr       <= '0;
            r_loc_cnt   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err_align <= 1'b0;
            r_err_count <= 1'b0;
            r_wr_idx    <= '0;
            r_rd_idx    <= '0;
            r_fifo_cnt  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.cfg_start) begin
                        r_num_ch   <= bus.cfg_num_ch;
                        r_ptr      <= bus.cfg_base_addr;
                        r_cur_base <= bus.cfg_base_addr;
                        r_ch       <= '0;
                        r_elem_cnt <= '0;
                        r_loc_cnt  <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_restart && (r_ch == r_num_ch)) r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (w_push) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase

            // An overshooting beat carries its excess elements into the next channel.
            if (w_accept) r_elem_cnt <= w_restart ? (w_sum - L_CH) : w_sum;

            if (w_restart) begin
                r_ch        <= r_ch + CH_W'(1);
                r_pend_ch   <= r_ch;
                r_pend_base <= r_cur_base;
                r_cur_base  <= w_ptr_next;
                if (w_sum != L_CH) r_err_align <= 1'b1;
            end
            r_pending <= w_restart || (r_pending && !bus.cu_count_valid);

            if (w_active) begin
                r_ptr     <= w_ptr_next;
                r_loc_cnt <= w_push ? CNT_W'(w_cu_pop) : (r_loc_cnt + CNT_W'(w_cu_pop));
            end
            if (w_push && (r_loc_cnt != bus.cu_count)) r_err_count <= 1'b1;

            if (w_push) r_wr_idx <= r_wr_idx + AW'(1);
            if (w_pop)  r_rd_idx <= r_rd_idx + AW'(1);
            r_fifo_cnt <= r_fifo_cnt + FW'(w_push) - FW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_ch[r_wr_idx]    <= r_pend_ch;
            r_mem_base[r_wr_idx]  <= r_pend_base;
            r_mem_count[r_wr_idx] <= bus.cu_count;
        end
    end
endmodule

// File: tb/tb_compress_channel_sequencer.sv
// tb/tb_compress_channel_sequencer.sv - directed and random checks of the channel sequencer against a cumulative-count model
module tb_compress_channel_sequencer;
    localparam int POOL_W   = 4;
    localparam int CH_ELEMS = 8;
    localparam int CH_W     = 6;
    localparam int CNT_W    = 8;
    localparam int ADDR_W   = 12;
    localparam int DEPTH    = 2;

    logic clk;
    logic rst;

    compress_channel_sequencer_if #(.POOL_W(POOL_W), .CH_W(CH_W), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) bus ();

    compress_channel_sequencer #(
        .POOL_W(POOL_W), .CH_ELEMS(CH_ELEMS), .CH_W(CH_W),
        .CNT_W(CNT_W), .ADDR_W(ADDR_W), .DESC_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {int ch; int base; int cnt;} desc_t;

    int    n_pass = 0;
    int    n_total = 0;
    bit    m_run, m_drain, m_donest, m_pend;
    int    m_num, m_ch, m_total, m_out, m_chbase, m_cfgbase;
    desc_t m_pd;
    desc_t q[$];
    bit    e_align, e_count;
    bit    cu_rep;
    int    cu_val, cu_real, cu_tally, force_d;
    logic  rdy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_run = 0; m_drain = 0; m_donest = 0; m_pend = 0;
        m_num = 0; m_ch = 0; m_total = 0; m_out = 0; m_chbase = 0; m_cfgbase = 0;
        m_pd = '{0, 0, 0};
        q.delete();
        e_align = 0; e_count = 0;
        cu_rep = 0; cu_val = 0; cu_real = 0; cu_tally = 0; force_d = 0;
    endtask

    // One clock: drive, check at negedge against the model, then advance the model.
    task automatic step(input logic [3:0] lv, input logic [3:0] cl, input bit dr,
                        input bit st, input int num, input int base, output logic o_rdy);
        bit active, exp_rdy, restart, next_done;
        int nt, clp;
        bus.cfg_start      = st;
        bus.cfg_num_ch     = CH_W'(num);
        bus.cfg_base_addr  = ADDR_W'(base);
        bus.in_lane_valid  = lv;
        bus.cu_lane_valid  = cl;
        bus.desc_ready     = dr;
        bus.cu_count_valid = cu_rep;
        bus.cu_count       = CNT_W'(cu_val);
        @(negedge clk);
        active  = m_run || m_drain || m_donest;
        exp_rdy = m_run && ((q.size() + int'(m_pend)) < DEPTH);
        clp     = active ? $countones(cl) : 0;
        nt      = m_total + $countones(lv);
        restart = exp_rdy && (lv != 0) && ((nt / CH_ELEMS) != (m_total / CH_ELEMS));
        o_rdy   = bus.in_ready;
        chk("in_ready", bus.in_ready, exp_rdy);
        chk("compress_restart", bus.compress_restart, restart);
        chk("wr_en", bus.wr_en, active && (cl != 0));
        chk("wr_addr", bus.wr_addr, (m_cfgbase + m_out) % 4096);
        chk("busy", bus.busy, active);
        chk("done", bus.done, m_donest);
        chk("err_align", bus.err_align, e_align);
        chk("err_count", bus.err_count, e_count);
        chk("desc_valid", bus.desc_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("desc_ch", bus.desc_ch, q[0].ch);
            chk("desc_base", bus.desc_base, q[0].base);
            chk("desc_count", bus.desc_count, q[0].cnt);
            if (dr) void'(q.pop_front());
        end
        next_done = 0;
        if (cu_rep && m_pend) begin
            q.push_back('{m_pd.ch, m_pd.base, cu_val % 256});
            if (cu_val != cu_real) e_count = 1;
            m_pend = 0;
            if (m_drain) begin
                m_drain = 0;
                next_done = 1;
            end
        end
        m_out = m_out + clp;
        if (exp_rdy && (lv != 0)) begin
            m_total = nt;
            if (restart) begin
                if ((nt % CH_ELEMS) != 0) e_align = 1;
                m_pd = '{m_ch, m_chbase, 0};
                m_pend = 1;
                m_chbase = (m_cfgbase + m_out) % 4096;
                if (m_ch == m_num) begin
                    m_run = 0;
                    m_drain = 1;
                end
                m_ch++;
            end
        end
        if (bus.compress_restart) begin
            cu_real  = cu_tally + $countones(cl);
            cu_val   = cu_real + force_d;
            force_d  = 0;
            cu_rep   = 1;
            cu_tally = 0;
        end else begin
            cu_rep   = 0;
            cu_tally = cu_tally + $countones(cl);
        end
        m_donest = next_done;
        if (st && !active) begin
            m_run = 1; m_cfgbase = base; m_out = 0; m_total = 0;
            m_ch = 0; m_num = num; m_chbase = base; cu_tally = 0;
        end
        @(posedge clk);
        #1;
        bus.cfg_start = 1'b0;
    endtask

    task automatic beat(input logic [3:0] lv, input logic [3:0] cl, input bit dr);
        step(lv, cl, dr, 1'b0, 0, 0, rdy);
    endtask

    task automatic start(input int num, input int base);
        step(4'h0, 4'h0, 1'b1, 1'b1, num, base, rdy);
    endtask

    // mode 0: idle inputs; 1: fully random; 2: full beats, random compressor lanes
    task automatic finish_run(input int mode);
        for (int i = 0; i < 400 && (m_run || m_drain || m_donest); i++) begin
            case (mode)
                0:       beat(4'h0, 4'h0, 1'b1);
                1:       beat(4'($urandom), 4'($urandom), $urandom_range(0, 3) != 0);
                default: beat(4'hf, 4'($urandom), 1'b1);
            endcase
        end
        chk("run_end_busy", bus.busy, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.cfg_start = 1'b0; bus.cfg_num_ch = '0; bus.cfg_base_addr = '0;
        bus.in_lane_valid = '0; bus.cu_lane_valid = '0; bus.cu_count = '0;
        bus.cu_count_valid = 1'b0; bus.desc_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        do_reset();
        do_reset();
        chk("reset_busy", bus.busy, 0);
        chk("reset_in_ready", bus.in_ready, 0);
        chk("reset_desc_valid", bus.desc_valid, 0);
        chk("reset_wr_addr", bus.wr_addr, 0);
        beat(4'h0, 4'h0, 1'b1);

        // two channels, dense data, every beat compressed to four words
        start(1, 'h100);
        for (int i = 0; i < 4; i++) beat(4'hf, 4'hf, 1'b1);
        finish_run(0);
        chk("A_end_addr", bus.wr_addr, 'h110);

        // channel 0 compresses to nothing, channel 1 to three words
        start(1, 'h300);
        beat(4'hf, 4'h0, 1'b1);
        beat(4'hf, 4'h0, 1'b1);
        beat(4'hf, 4'h3, 1'b1);
        beat(4'hf, 4'h1, 1'b1);
        finish_run(0);
        chk("Z_err_count", bus.err_count, 0);

        for (int r = 0; r < 6; r++) begin
            start($urandom_range(0, 4), $urandom_range(0, 4095));
            finish_run(1);
        end

        // descriptor back-pressure with a two-entry FIFO
        start(3, 'h200);
        for (int i = 0; i < 7; i++) beat(4'hf, 4'($urandom), 1'b0);
        chk("bp_stall", rdy, 0);
        beat(4'hf, 4'h1, 1'b1);
        beat(4'hf, 4'h1, 1'b0);
        chk("bp_resume", rdy, 1);
        finish_run(2);

        // beat straddling a channel boundary
        start(1, 'hff0);
        beat(4'h3, 4'h1, 1'b1);
        beat(4'hf, 4'h2, 1'b1);
        beat(4'hf, 4'h4, 1'b1);
        beat(4'hf, 4'h8, 1'b1);
        chk("align_sticky", bus.err_align, 1);
        beat(4'h3, 4'h3, 1'b1);
        beat(4'hf, 4'h0, 1'b1);
        beat(4'hf, 4'hf, 1'b1);
        finish_run(0);

        // compressor reports one more value than it emitted
        force_d = 1;
        start(1, 'h040);
        finish_run(2);
        chk("count_sticky", bus.err_count, 1);

        // reset in the middle of channel 1
        start(2, 'h500);
        for (int i = 0; i < 3; i++) beat(4'hf, 4'($urandom), 1'b1);
        do_reset();
        chk("rst_busy", bus.busy, 0);
        chk("rst_desc_valid", bus.desc_valid, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_err_align", bus.err_align, 0);
        beat(4'h0, 4'h0, 1'b1);
        start(1, 'h020);
        finish_run(1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
